// File: rtl/fpu_pkg.sv
// Shared constants for the FPU datapath blocks.
package fpu_pkg;

    localparam int unsigned BIAS    = 127;
    localparam int unsigned EXP_MAX = 255;
    localparam int unsigned MANT_W  = 23;
    localparam int unsigned PROD_W  = 48;
    localparam int unsigned FLAG_W  = 3;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    // Bit positions inside the {overflow, underflow, inexact} flag vector
    localparam int unsigned FLG_OVF = 2;
    localparam int unsigned FLG_UNF = 1;
    localparam int unsigned FLG_INX = 0;

endpackage

// File: rtl/fmul_rne_round.sv
// Round-to-nearest-even on a normalized mantissa, with carry renormalization.
module fmul_rne_round
    import fpu_pkg::MANT_W;
#(
    parameter int unsigned EXP_W = 10
) (
    input  logic [MANT_W-1:0] mant,
    input  logic              guard,
    input  logic              sticky,
    input  logic [EXP_W-1:0]  exp,
    output logic [MANT_W-1:0] mant_c,
    output logic [EXP_W-1:0]  exp_c,
    output logic              inexact_c
);

    logic          round_up;
    logic [MANT_W:0] sum;

    // Increment on G with (S or odd LSB); a carry out means 1.111.. became 10.000..
    always_comb begin
        round_up  = guard & (sticky | mant[0]);
        sum       = {1'b0, mant} + (MANT_W+1)'(round_up);
        mant_c    = sum[MANT_W-1:0];
        exp_c     = sum[MANT_W] ? exp + EXP_W'(1) : exp;
        inexact_c = guard | sticky;
    end

endmodule

// File: rtl/fmul_norm_round.sv
// Final multiplier stage: normalize (S1), round/range-check/pack (S2).
module fmul_norm_round
    import fpu_pkg::EXP_MAX;
    import fpu_pkg::QNAN;
    import fpu_pkg::MANT_W;
    import fpu_pkg::PROD_W;
    import fpu_pkg::FLAG_W;
    import fpu_pkg::FLG_OVF;
    import fpu_pkg::FLG_UNF;
    import fpu_pkg::FLG_INX;
#(
    parameter int unsigned EXP_W = 10,
    parameter int unsigned BIAS  = fpu_pkg::BIAS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sign,
    input  logic [EXP_W-1:0]  in_exp,
    input  logic [PROD_W-1:0] in_prod,
    input  logic              in_is_nan,
    input  logic              in_is_inf,
    input  logic              in_is_zero,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_result,
    output logic [FLAG_W-1:0] out_flags
);

    // Smallest exponent that no longer fits a finite binary32 value
    localparam logic signed [EXP_W-1:0] OVF_EXP  = EXP_W'(2 * BIAS + 1);
    localparam logic signed [EXP_W-1:0] ZERO_EXP = '0;

    // Stage 1 registers
    logic              s1_valid;
    logic              s1_sign;
    logic [EXP_W-1:0]  s1_exp;
    logic [MANT_W-1:0] s1_mant;
    logic              s1_guard;
    logic              s1_sticky;
    logic              s1_nan;
    logic              s1_inf;
    logic              s1_zero;

    // Stage 2 (output) valid
    logic              s2_valid;

    logic              s2_adv;
    logic              s1_adv;

    // Normalizer combinational outputs
    logic [EXP_W-1:0]  norm_exp_c;
    logic [MANT_W-1:0] norm_mant_c;
    logic              norm_guard_c;
    logic              norm_sticky_c;

    // Rounder and packer combinational outputs
    logic [MANT_W-1:0]       rnd_mant;
    logic signed [EXP_W-1:0] rnd_exp;
    logic                    rnd_inexact;
    logic [31:0]             pack_result_c;
    logic [FLAG_W-1:0]       pack_flags_c;

    // Pipeline advance conditions; in_ready is the S1 advance
    always_comb begin
        s2_adv   = out_ready | ~s2_valid;
        s1_adv   = s2_adv | ~s1_valid;
        in_ready = s1_adv;
    end

    // Normalize the 1.m x 1.m product into [1,2) and extract guard/sticky
    always_comb begin
        if (in_prod[PROD_W-1]) begin
            norm_mant_c   = in_prod[46:24];
            norm_guard_c  = in_prod[23];
            norm_sticky_c = |in_prod[22:0];
            norm_exp_c    = in_exp + EXP_W'(1);
        end else begin
            norm_mant_c   = in_prod[45:23];
            norm_guard_c  = in_prod[22];
            norm_sticky_c = |in_prod[21:0];
            norm_exp_c    = in_exp;
        end
    end

    // S1 register: capture the normalized beat when the stage advances
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_sign   <= 1'b0;
            s1_exp    <= '0;
            s1_mant   <= '0;
            s1_guard  <= 1'b0;
            s1_sticky <= 1'b0;
            s1_nan    <= 1'b0;
            s1_inf    <= 1'b0;
            s1_zero   <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sign   <= in_sign;
                s1_exp    <= norm_exp_c;
                s1_mant   <= norm_mant_c;
                s1_guard  <= norm_guard_c;
                s1_sticky <= norm_sticky_c;
                s1_nan    <= in_is_nan;
                s1_inf    <= in_is_inf;
                s1_zero   <= in_is_zero;
            end
        end
    end

    fmul_rne_round #(
        .EXP_W (EXP_W)
    ) u_round (
        .mant      (s1_mant),
        .guard     (s1_guard),
        .sticky    (s1_sticky),
        .exp       (s1_exp),
        .mant_c    (rnd_mant),
        .exp_c     (rnd_exp),
        .inexact_c (rnd_inexact)
    );

    // Special-case priority, then post-rounding range check, then pack
    always_comb begin
        pack_result_c = '0;
        pack_flags_c  = '0;
        if (s1_nan) begin
            pack_result_c = QNAN;
        end else if (s1_inf) begin
            pack_result_c = {s1_sign, 8'(EXP_MAX), 23'd0};
        end else if (s1_zero) begin
            pack_result_c = {s1_sign, 31'd0};
        end else if (rnd_exp >= OVF_EXP) begin
            pack_result_c          = {s1_sign, 8'(EXP_MAX), 23'd0};
            pack_flags_c[FLG_OVF]  = 1'b1;
            pack_flags_c[FLG_INX]  = 1'b1;
        end else if (rnd_exp <= ZERO_EXP) begin
            pack_result_c          = {s1_sign, 31'd0};
            pack_flags_c[FLG_UNF]  = 1'b1;
            pack_flags_c[FLG_INX]  = 1'b1;
        end else begin
            pack_result_c          = {s1_sign, rnd_exp[7:0], rnd_mant};
            pack_flags_c[FLG_INX]  = rnd_inexact;
        end
    end

    // S2 register: output holds while the consumer stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid   <= 1'b0;
            out_result <= '0;
            out_flags  <= '0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_result <= pack_result_c;
                out_flags  <= pack_flags_c;
            end
        end
    end

    assign out_valid = s2_valid;

endmodule

// File: tb/tb_fmul_norm_round.sv
// Scoreboard bench for fmul_norm_round with directed vectors.
module tb_fmul_norm_round;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [9:0]  in_exp;
    logic [47:0] in_prod;
    logic        in_is_nan;
    logic        in_is_inf;
    logic        in_is_zero;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [2:0]  out_flags;

    int checks = 0;
    int errors = 0;
    logic [34:0] sb[$];
    int          popped = 0;
    bit          saw_in_ready_low = 0;

    always #5 clk = ~clk;

    fmul_norm_round dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sign    (in_sign),
        .in_exp     (in_exp),
        .in_prod    (in_prod),
        .in_is_nan  (in_is_nan),
        .in_is_inf  (in_is_inf),
        .in_is_zero (in_is_zero),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_flags  (out_flags)
    );

    task automatic check(input string name, input logic [34:0] act, input logic [34:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Present one beat; push the expected response once it is accepted
    task automatic send(input logic sg, input logic [9:0] ex, input logic [47:0] pr,
                        input logic nan, input logic inf, input logic zero,
                        input logic [31:0] eres, input logic [2:0] eflg);
        int  waited = 0;
        bit  acc    = 0;
        @(negedge clk);
        in_valid   = 1'b1;
        in_sign    = sg;
        in_exp     = ex;
        in_prod    = pr;
        in_is_nan  = nan;
        in_is_inf  = inf;
        in_is_zero = zero;
        while (!acc) begin
            #1;
            acc = in_ready;
            if (acc) sb.push_back({eres, eflg});
            @(posedge clk);
            if (!acc) begin
                waited++;
                if (waited > 50) begin
                    checks++;
                    errors++;
                    $display("FAIL send_timeout: in_ready stuck low, required 1");
                    acc = 1;
                end else begin
                    @(negedge clk);
                end
            end
        end
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Monitor: pops on every transfer and checks hold stability during stalls
    initial begin : monitor
        bit          stall_prev = 0;
        logic [31:0] held_res;
        logic [2:0]  held_flg;
        logic [34:0] expv;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                stall_prev = 0;
            end else begin
                if (stall_prev) begin
                    check("stall_hold", {out_valid, out_result, out_flags} & 35'h7_FFFF_FFFF,
                          {1'b1, held_res, held_flg} & 35'h7_FFFF_FFFF);
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_beat: got %h/%b, required no output", out_result, out_flags);
                    end else begin
                        expv = sb.pop_front();
                        check($sformatf("beat%0d", popped), {out_result, out_flags}, expv);
                        popped++;
                    end
                end
                stall_prev = out_valid && !out_ready;
                held_res   = out_result;
                held_flg   = out_flags;
            end
        end
    end

    initial begin : stim
        int n;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_sign    = 1'b0;
        in_exp     = '0;
        in_prod    = '0;
        in_is_nan  = 1'b0;
        in_is_inf  = 1'b0;
        in_is_zero = 1'b0;
        out_ready  = 1'b1;

        // Reset state
        #2;
        check("reset_out", {out_valid, out_result, out_flags}, 35'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #2;
        check("ready_after_reset", 35'(in_ready), 35'd1);

        // 1.5 x 1.5 and two-edge latency
        send(1'b0, 10'd127, 48'h9000_0000_0000, 0, 0, 0, 32'h4010_0000, 3'b000);
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        check("latency_edge1", 35'(out_valid), 35'd0);
        @(negedge clk);
        #2;
        check("latency_edge2", 35'(out_valid), 35'd1);

        // Rounding cases
        send(1'b0, 10'd127, 48'h4000_0040_0000, 0, 0, 0, 32'h3F80_0000, 3'b001);
        send(1'b0, 10'd127, 48'h4000_00C0_0000, 0, 0, 0, 32'h3F80_0002, 3'b001);
        send(1'b0, 10'd127, 48'h7FFF_FFFF_FFFF, 0, 0, 0, 32'h4000_0000, 3'b001);
        // Range checks
        send(1'b0, 10'd254, 48'h8000_0000_0000, 0, 0, 0, 32'h7F80_0000, 3'b101);
        send(1'b0, 10'd0,   48'h4000_0000_0000, 0, 0, 0, 32'h0000_0000, 3'b011);
        send(1'b1, 10'h3FB, 48'h4000_0000_0000, 0, 0, 0, 32'h8000_0000, 3'b011);
        // Specials
        send(1'b0, 10'd127, 48'h4000_0000_0000, 1, 1, 0, 32'h7FC0_0000, 3'b000);
        send(1'b1, 10'd127, 48'h4000_0000_0000, 0, 1, 0, 32'hFF80_0000, 3'b000);
        send(1'b0, 10'd127, 48'h4000_0000_0000, 0, 0, 1, 32'h0000_0000, 3'b000);
        idle();
        repeat (4) @(negedge clk);

        // Backpressure: 5 beats, consumer stalls from the third cycle
        fork
            begin
                for (int i = 0; i < 5; i++) begin
                    send(1'b0, 10'(100 + i), 48'h4000_0000_0000, 0, 0, 0,
                         {1'b0, 8'(100 + i), 23'd0}, 3'b000);
                end
                idle();
            end
            begin
                repeat (2) @(negedge clk);
                out_ready = 1'b0;
                for (int k = 0; k < 6; k++) begin
                    @(negedge clk);
                    #1;
                    if (!in_ready) saw_in_ready_low = 1;
                end
                @(negedge clk);
                out_ready = 1'b1;
            end
        join
        check("bp_in_ready_dropped", 35'(saw_in_ready_low), 35'd1);
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("bp_drained", 35'(sb.size()), 35'd0);

        // Reset with two beats in flight
        @(negedge clk);
        out_ready = 1'b0;
        send(1'b0, 10'd127, 48'h4000_0000_0000, 0, 0, 0, 32'h3F80_0000, 3'b000);
        send(1'b0, 10'd128, 48'h4000_0000_0000, 0, 0, 0, 32'h4000_0000, 3'b000);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("inflight_valid", 35'(out_valid), 35'd1);
        @(negedge clk);
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("reset_drops", {out_valid, out_result, out_flags}, 35'd0);
        repeat (2) @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        repeat (6) @(negedge clk);
        #3;
        check("no_stale", 35'(out_valid), 35'd0);

        // Fresh beat after reset
        send(1'b0, 10'd127, 48'h9000_0000_0000, 0, 0, 0, 32'h4010_0000, 3'b000);
        idle();
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        check("final_drained", 35'(sb.size()), 35'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
